sraml_bridge: RTL and testbench
===============================

Name: sraml_bridge

Overview:
- Converts the core's single-cycle SRAM-style port (en/wen/addr/wdata/rdata) into an SRAM-like handshake (req, wr, size, addr_ok, data_ok).
- Generates the stall that the datapath consumes as i_stall/d_stall, and holds returned read data while the whole pipeline (all_stall) is frozen.
- Parametrised so that one block serves both the instruction and the data side.
- Supports cancelling an in-flight access on pipeline flush (exception/eret), which the direct-SRAM top cannot do.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be 32 or 64.
- IS_INST, 0, 1 = instruction side: wr forced 0, wen and wdata ignored.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- cpu_en  in  1  access request from the pipeline; held stable while stall=1.
- cpu_wen  in  DATA_W/8  byte write enables; 0 = read.
- cpu_size  in  2  read size: 0 byte, 1 half, 2 word, 3 dword (dword only when DATA_W=64).
- cpu_addr  in  ADDR_W  physical byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid while state==DONE.
- stall  out  1  this port is not finished.
- all_stall  in  1  global pipeline stall.
- flush  in  1  discard the current access.
- req  out  1  SRAM-like request.
- wr  out  1  write.
- size  out  2  transfer size.
- addr  out  ADDR_W  byte address.
- wdata  out  DATA_W  write data.
- addr_ok  in  1  address accepted.
- data_ok  in  1  data returned, or write completed.
- rdata  in  DATA_W  read data.

Behaviour:
- State machine states: IDLE, WAIT_DATA, DONE, DISCARD.
- Reset (rst=1 at a clk edge):
  - state=IDLE, rdata_r=0.
  - Outputs req=0, stall=0, cpu_rdata=0.
- req is combinational: req = (state==IDLE) & cpu_en & ~flush.
- addr, wdata, wr and size are driven combinationally from the cpu_* inputs.
- wr = |cpu_wen & ~IS_INST.
- size for writes is encoded from cpu_wen:
  - single bit set -> 0.
  - 2'b11 aligned pair -> 1.
  - 4'hF -> 2.
  - all ones at DATA_W=64 -> 3.
  - Any other pattern: size=2 and the sticky error flag err_r is set (visible in simulation only).
- size for reads = cpu_size.
- IDLE:
  - req & addr_ok & data_ok -> DONE; capture rdata into rdata_r.
  - req & addr_ok & ~data_ok -> WAIT_DATA.
  - Otherwise stay in IDLE.
- WAIT_DATA: req=0.
  - flush & ~data_ok -> DISCARD.
  - data_ok -> DONE; capture rdata into rdata_r. This applies even if flush=1, in which case the data is discarded by the pipeline.
- DONE:
  - ~all_stall -> IDLE.
  - all_stall -> stay; rdata_r is held unchanged.
- DISCARD:
  - data_ok -> IDLE; rdata is dropped and rdata_r is not updated.
  - A new request is not issued before IDLE is reached.
- stall = cpu_en & ~flush & (state!=DONE) | (state==DISCARD).
- cpu_rdata = rdata_r.
- Latency from cpu_en with zero-wait memory: DONE is reached 1 cycle later, so stall is high for 1 cycle.
- Only one access is outstanding at a time.
- addr_ok arriving outside IDLE&req is ignored.
- Simultaneous events:
  - flush in IDLE: no req issued, no state change.
  - flush and addr_ok in the same cycle cannot occur because req is gated.
- Reset mid-operation: the block returns to IDLE immediately. The memory side is also reset on the same rst, so no late data_ok arrives.

Decomposition:
- Package sraml_pkg:
  - State enum (IDLE=0, WAIT_DATA=1, DONE=2, DISCARD=3).
  - SIZE_B/SIZE_H/SIZE_W/SIZE_D constants.
- Sub-module sraml_size_enc: combinational wen->size encoder with err output, parametrised by DATA_W.

Test Plan:
- Word read, zero-wait: cpu_en=1, wen=0, addr=0x1FC00000; memory gives addr_ok=data_ok=1 in the same cycle with rdata=0x3C1D0001 -> req high 1 cycle, stall high 1 cycle, DONE next cycle, cpu_rdata=0x3C1D0001.
- Byte write with delay: wen=4'b0100, wdata=0x00AB0000; addr_ok after 2 cycles, data_ok 3 cycles later -> wr=1, size=0; stall high 6 cycles total; exactly one req handshake.
- Hold under global stall: read completes with rdata=0xDEADBEEF, all_stall=1 for 4 cycles, rdata input changes to 0x0 -> state stays DONE, cpu_rdata stays 0xDEADBEEF; IDLE 1 cycle after all_stall falls.
- Flush in flight: addr_ok accepted, flush pulses in WAIT_DATA, data_ok 2 cycles later with 0x12345678, new cpu_en present -> state is DISCARD, rdata_r unchanged, no req until IDLE, then the new req is issued.
- IS_INST=1 with cpu_wen=4'hF -> wr=0, size=cpu_size.
- DATA_W=64: wen=8'hFF -> size=3. Mid-WAIT_DATA rst=1 -> next cycle state=IDLE, stall=0, cpu_rdata=0.

Source files
------------

// File: rtl/sraml_pkg.sv
// Shared types and constants for the SRAM-like bridge: FSM states and
// transfer-size encodings.
package sraml_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    DONE      = 2'd2,
    DISCARD   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/sraml_size_enc.sv
// Maps a byte-write-enable mask onto a transfer size; flags masks that no
// single aligned transfer can express.
module sraml_size_enc
  import sraml_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W/8-1:0] wen_i,
  output logic [1:0]          size_o,
  output logic                err_o
);

  localparam int NB = DATA_W / 8;

  logic [NB/2-1:0] pair_hit;
  logic [NB/4-1:0] word_hit;

  generate
    for (genvar gi = 0; gi < NB / 2; gi++) begin : g_pair
      assign pair_hit[gi] = (wen_i == (NB'(2'b11) << (2 * gi)));
    end
    for (genvar gi = 0; gi < NB / 4; gi++) begin : g_word
      assign word_hit[gi] = (wen_i == (NB'(4'hF) << (4 * gi)));
    end
  endgenerate

  always_comb begin
    size_o = SIZE_W;
    err_o  = 1'b0;
    if ($onehot(wen_i)) begin
      size_o = SIZE_B;
    end else if (|pair_hit) begin
      size_o = SIZE_H;
    end else if (|word_hit) begin
      size_o = SIZE_W;
    end else if ((NB == 8) && (&wen_i)) begin
      size_o = SIZE_D;
    end else if (|wen_i) begin
      // Unaligned or sparse mask: issue a word and remember the misuse.
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/sraml_bridge.sv
// Bridges the core's single-cycle SRAM port onto an SRAM-like handshake,
// producing the pipeline stall and holding read data while the pipe is frozen.
module sraml_bridge
  import sraml_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IS_INST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                stall,
  input  logic                all_stall,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q;
  logic [1:0]          enc_size;
  logic                enc_err;
  logic                is_write;

  sraml_size_enc #(.DATA_W(DATA_W)) u_size_enc (
    .wen_i  (cpu_wen),
    .size_o (enc_size),
    .err_o  (enc_err)
  );

  assign is_write  = (|cpu_wen) && (IS_INST == 0);
  assign wr        = is_write;
  assign size      = is_write ? enc_size : cpu_size;
  assign addr      = cpu_addr;
  assign wdata     = cpu_wdata;
  assign req       = (state_q == IDLE) && cpu_en && !flush;
  assign stall     = (cpu_en && !flush && (state_q != DONE)) || (state_q == DISCARD);
  assign cpu_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req && addr_ok) begin
          if (data_ok) begin
            state_d = DONE;
            rdata_d = rdata;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        // Data arriving alongside a flush still lands; the pipeline drops it.
        if (data_ok) begin
          state_d = DONE;
          rdata_d = rdata;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DONE: begin
        if (!all_stall) begin
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_q | (cpu_en & is_write & enc_err);
    end
  end

endmodule

// File: tb/tb_sraml_bridge.sv
// Directed bench for sraml_bridge: data-side, instruction-side and 64-bit
// instances, a table of size/wr vectors plus handshake sequences.
module tb_sraml_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32-bit instances.
  logic        cpu_en, all_stall, flush, addr_ok, data_ok;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, rdata;

  logic [31:0] m_cpu_rdata, m_addr, m_wdata;
  logic        m_stall, m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] i_cpu_rdata, i_addr, i_wdata;
  logic        i_stall, i_req, i_wr;
  logic [1:0]  i_size;

  logic        d_cpu_en, d_all_stall, d_flush, d_addr_ok, d_data_ok;
  logic [7:0]  d_cpu_wen;
  logic [1:0]  d_cpu_size;
  logic [31:0] d_cpu_addr, d_addr;
  logic [63:0] d_cpu_wdata, d_rdata, d_cpu_rdata, d_wdata;
  logic        d_stall, d_req, d_wr;
  logic [1:0]  d_size;

  sraml_bridge #(.ADDR_W(32), .DATA_W(32), .IS_INST(0)) u_main (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(m_cpu_rdata), .stall(m_stall),
    .all_stall(all_stall), .flush(flush), .req(m_req), .wr(m_wr), .size(m_size),
    .addr(m_addr), .wdata(m_wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sraml_bridge #(.ADDR_W(32), .DATA_W(32), .IS_INST(1)) u_inst (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(i_cpu_rdata), .stall(i_stall),
    .all_stall(all_stall), .flush(flush), .req(i_req), .wr(i_wr), .size(i_size),
    .addr(i_addr), .wdata(i_wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sraml_bridge #(.ADDR_W(32), .DATA_W(64), .IS_INST(0)) u_d64 (
    .clk(clk), .rst(rst), .cpu_en(d_cpu_en), .cpu_wen(d_cpu_wen), .cpu_size(d_cpu_size),
    .cpu_addr(d_cpu_addr), .cpu_wdata(d_cpu_wdata), .cpu_rdata(d_cpu_rdata), .stall(d_stall),
    .all_stall(d_all_stall), .flush(d_flush), .req(d_req), .wr(d_wr), .size(d_size),
    .addr(d_addr), .wdata(d_wdata), .addr_ok(d_addr_ok), .data_ok(d_data_ok), .rdata(d_rdata)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int unsigned inst;     // 0 data-side, 1 instruction-side, 2 64-bit
    logic [7:0]  wen;
    logic [1:0]  csize;
    logic        exp_wr;
    logic [1:0]  exp_size;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic       got_wr;
    logic [1:0] got_size;
    int         n_stall;
    int         n_hs;

    vecs[0]  = '{0, 8'h00, 2'd2, 1'b0, 2'd2};
    vecs[1]  = '{0, 8'h00, 2'd0, 1'b0, 2'd0};
    vecs[2]  = '{0, 8'h00, 2'd1, 1'b0, 2'd1};
    vecs[3]  = '{0, 8'h01, 2'd2, 1'b1, 2'd0};
    vecs[4]  = '{0, 8'h08, 2'd2, 1'b1, 2'd0};
    vecs[5]  = '{0, 8'h03, 2'd0, 1'b1, 2'd1};
    vecs[6]  = '{0, 8'h0C, 2'd0, 1'b1, 2'd1};
    vecs[7]  = '{0, 8'h0F, 2'd0, 1'b1, 2'd2};
    vecs[8]  = '{0, 8'h06, 2'd0, 1'b1, 2'd2};
    vecs[9]  = '{0, 8'h05, 2'd0, 1'b1, 2'd2};
    vecs[10] = '{1, 8'h0F, 2'd0, 1'b0, 2'd0};
    vecs[11] = '{1, 8'h01, 2'd1, 1'b0, 2'd1};
    vecs[12] = '{2, 8'hFF, 2'd0, 1'b1, 2'd3};
    vecs[13] = '{2, 8'hF0, 2'd0, 1'b1, 2'd2};
    vecs[14] = '{2, 8'h30, 2'd0, 1'b1, 2'd1};
    vecs[15] = '{2, 8'h3C, 2'd0, 1'b1, 2'd2};

    rst = 1'b1;
    cpu_en = 0; all_stall = 0; flush = 0; addr_ok = 0; data_ok = 0;
    cpu_wen = 0; cpu_size = 2'd2; cpu_addr = 0; cpu_wdata = 0; rdata = 0;
    d_cpu_en = 0; d_all_stall = 0; d_flush = 0; d_addr_ok = 0; d_data_ok = 0;
    d_cpu_wen = 0; d_cpu_size = 2'd3; d_cpu_addr = 0; d_cpu_wdata = 0; d_rdata = 0;
    tick();
    tick();
    chk("reset_req", 64'(m_req), 64'd0);
    chk("reset_stall", 64'(m_stall), 64'd0);
    chk("reset_rdata", 64'(m_cpu_rdata), 64'd0);
    chk("reset_rdata64", d_cpu_rdata, 64'd0);
    rst = 1'b0;
    tick();

    // Size/wr encoding table, applied with no access pending.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].inst < 2) begin
        cpu_wen = vecs[i].wen[3:0];
        cpu_size = vecs[i].csize;
      end else begin
        d_cpu_wen = vecs[i].wen;
        d_cpu_size = vecs[i].csize;
      end
      #1;
      case (vecs[i].inst)
        0:       begin got_wr = m_wr; got_size = m_size; end
        1:       begin got_wr = i_wr; got_size = i_size; end
        default: begin got_wr = d_wr; got_size = d_size; end
      endcase
      chk($sformatf("vec%0d_wr", i), 64'(got_wr), 64'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_size", i), 64'(got_size), 64'(vecs[i].exp_size));
    end
    cpu_wen = 0; cpu_size = 2'd2; d_cpu_wen = 0;
    tick();

    // Zero-wait word read.
    cpu_en = 1; cpu_addr = 32'h1FC0_0000; addr_ok = 1; data_ok = 1; rdata = 32'h3C1D_0001;
    #1;
    chk("rd0_req", 64'(m_req), 64'd1);
    chk("rd0_stall", 64'(m_stall), 64'd1);
    chk("rd0_addr", 64'(m_addr), 64'h1FC0_0000);
    chk("rd0_inst_req", 64'(i_req), 64'd1);
    tick();
    addr_ok = 0; data_ok = 0;
    #1;
    chk("rd0_done_stall", 64'(m_stall), 64'd0);
    chk("rd0_done_req", 64'(m_req), 64'd0);
    chk("rd0_rdata", 64'(m_cpu_rdata), 64'h3C1D_0001);
    cpu_en = 0;
    tick();

    // Byte write, addr_ok after 2 cycles, data_ok 3 cycles after that.
    cpu_en = 1; cpu_wen = 4'b0100; cpu_wdata = 32'h00AB_0000; cpu_addr = 32'h0000_1002;
    n_stall = 0; n_hs = 0;
    #1;
    chk("wr_wr", 64'(m_wr), 64'd1);
    chk("wr_size", 64'(m_size), 64'd0);
    chk("wr_wdata", 64'(m_wdata), 64'h00AB_0000);
    for (int k = 0; k <= 6; k++) begin
      addr_ok = (k == 2);
      data_ok = (k == 5);
      #1;
      if (m_stall) n_stall++;
      if (m_req && addr_ok) n_hs++;
      tick();
    end
    chk("wr_stall_cycles", 64'(n_stall), 64'd6);
    chk("wr_handshakes", 64'(n_hs), 64'd1);
    cpu_en = 0; cpu_wen = 0; addr_ok = 0; data_ok = 0;
    tick();

    // Hold read data under global stall.
    cpu_en = 1; addr_ok = 1; data_ok = 1; rdata = 32'hDEAD_BEEF;
    tick();
    addr_ok = 0; data_ok = 0; rdata = 32'h0; all_stall = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("hold%0d_stall", k), 64'(m_stall), 64'd0);
      chk($sformatf("hold%0d_rdata", k), 64'(m_cpu_rdata), 64'hDEAD_BEEF);
      tick();
    end
    all_stall = 0;
    #1;
    chk("hold_release_stall", 64'(m_stall), 64'd0);
    tick();
    chk("hold_idle_req", 64'(m_req), 64'd1);
    chk("hold_idle_rdata", 64'(m_cpu_rdata), 64'hDEAD_BEEF);
    cpu_en = 0;
    tick();

    // Flush while idle: no request, state unchanged.
    cpu_en = 1; flush = 1;
    #1;
    chk("fidle_req", 64'(m_req), 64'd0);
    chk("fidle_stall", 64'(m_stall), 64'd0);
    tick();
    flush = 0;
    #1;
    chk("fidle_after_req", 64'(m_req), 64'd1);

    // Flush while waiting for data.
    addr_ok = 1; cpu_addr = 32'h0000_2000;
    tick();
    addr_ok = 0; flush = 1;
    #1;
    chk("fwait_req", 64'(m_req), 64'd0);
    chk("fwait_stall", 64'(m_stall), 64'd0);
    tick();
    flush = 0; cpu_addr = 32'h0000_3000;
    #1;
    chk("disc_req", 64'(m_req), 64'd0);
    chk("disc_stall", 64'(m_stall), 64'd1);
    tick();
    data_ok = 1; rdata = 32'h1234_5678;
    #1;
    chk("disc_data_req", 64'(m_req), 64'd0);
    chk("disc_data_stall", 64'(m_stall), 64'd1);
    tick();
    data_ok = 0;
    #1;
    chk("disc_idle_req", 64'(m_req), 64'd1);
    chk("disc_rdata_kept", 64'(m_cpu_rdata), 64'hDEAD_BEEF);
    addr_ok = 1; data_ok = 1; rdata = 32'hCAFE_0001;
    tick();
    addr_ok = 0; data_ok = 0;
    chk("disc_new_rdata", 64'(m_cpu_rdata), 64'hCAFE_0001);
    cpu_en = 0;
    tick();

    // 64-bit instance: dword read, then reset while waiting for data.
    d_cpu_en = 1; d_cpu_size = 2'd3; d_addr_ok = 1; d_data_ok = 1; d_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("d64_rd_size", 64'(d_size), 64'd3);
    tick();
    chk("d64_rdata", d_cpu_rdata, 64'h0123_4567_89AB_CDEF);
    d_addr_ok = 0; d_data_ok = 0;
    tick();
    d_addr_ok = 1;
    tick();
    d_addr_ok = 0;
    #1;
    chk("d64_wait_stall", 64'(d_stall), 64'd1);
    chk("d64_wait_req", 64'(d_req), 64'd0);
    rst = 1; d_cpu_en = 0;
    tick();
    rst = 0;
    chk("d64_rst_stall", 64'(d_stall), 64'd0);
    chk("d64_rst_req", 64'(d_req), 64'd0);
    chk("d64_rst_rdata", d_cpu_rdata, 64'd0);
    d_cpu_en = 1;
    #1;
    chk("d64_rst_idle_req", 64'(d_req), 64'd1);
    d_cpu_en = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
